// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: one-cycle command pulses, preset
// digits in, registered MM:SS digits and state flags out.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] set_sl;
  logic [3:0] set_sh;
  logic [3:0] set_ml;
  logic [3:0] set_mh;
  logic [3:0] SL;
  logic [3:0] SH;
  logic [3:0] ML;
  logic [3:0] MH;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output tick, load, start, pause, clear,
    output set_sl, set_sh, set_ml, set_mh,
    input  SL, SH, ML, MH, running, done, alarm
  );

  modport slave (
    input  tick, load, start, pause, clear,
    input  set_sl, set_sh, set_ml, set_mh,
    output SL, SH, ML, MH, running, done, alarm
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/pause/clear control and a
// one-cycle alarm pulse when the count reaches 00:00.
module countdown_timer (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] sl_q, sl_d;
  logic [3:0] sh_q, sh_d;
  logic [3:0] ml_q, ml_d;
  logic [3:0] mh_q, mh_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       alarm_q, alarm_d;

  logic       count_nonzero;
  logic [3:0] dec_sl, dec_sh, dec_ml, dec_mh;
  logic       dec_zero;

  function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  assign count_nonzero = (sl_q != '0) || (sh_q != '0) || (ml_q != '0) || (mh_q != '0);

  // One-second decrement with BCD borrow; only used in RUN, where the count is never 00:00.
  always_comb begin
    dec_sl = sl_q;
    dec_sh = sh_q;
    dec_ml = ml_q;
    dec_mh = mh_q;
    if (sl_q != '0) begin
      dec_sl = sl_q - 4'd1;
    end else begin
      dec_sl = 4'd9;
      if (sh_q != '0) begin
        dec_sh = sh_q - 4'd1;
      end else begin
        dec_sh = 4'd5;
        if (ml_q != '0) begin
          dec_ml = ml_q - 4'd1;
        end else begin
          dec_ml = 4'd9;
          dec_mh = mh_q - 4'd1;
        end
      end
    end
    dec_zero = (dec_sl == '0) && (dec_sh == '0) && (dec_ml == '0) && (dec_mh == '0);
  end

  // Priority chain: clear > load > pause > start > tick. Each branch is
  // gated by its legal states so an ignored command falls through.
  always_comb begin
    state_d = state_q;
    sl_d    = sl_q;
    sh_d    = sh_q;
    ml_d    = ml_q;
    mh_d    = mh_q;
    alarm_d = 1'b0;

    if (bus.clear) begin
      state_d = ST_IDLE;
      sl_d    = '0;
      sh_d    = '0;
      ml_d    = '0;
      mh_d    = '0;
    end else if (bus.load && (state_q != ST_RUN)) begin
      state_d = ST_IDLE;
      sl_d    = clamp(bus.set_sl, 4'd9);
      sh_d    = clamp(bus.set_sh, 4'd5);
      ml_d    = clamp(bus.set_ml, 4'd9);
      mh_d    = clamp(bus.set_mh, 4'd9);
    end else if (bus.pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (bus.start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) && count_nonzero) begin
      state_d = ST_RUN;
    end else if (bus.tick && (state_q == ST_RUN)) begin
      sl_d = dec_sl;
      sh_d = dec_sh;
      ml_d = dec_ml;
      mh_d = dec_mh;
      if (dec_zero) begin
        state_d = ST_DONE;
        alarm_d = 1'b1;
      end
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sl_q      <= '0;
      sh_q      <= '0;
      ml_q      <= '0;
      mh_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sl_q      <= sl_d;
      sh_q      <= sh_d;
      ml_q      <= ml_d;
      mh_q      <= mh_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.SL      = sl_q;
  assign bus.SH      = sh_q;
  assign bus.ML      = ml_q;
  assign bus.MH      = mh_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;

endmodule
